// File: rtl/button_press_arbiter_pkg.sv
// Shared types and sizing helpers for the push-button front end.
package button_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  localparam int DEF_DIV    = 16;
  localparam int DEF_STABLE = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/button_press_arbiter_if.sv
// Event offer port: the arbiter presents ev_id with ev_valid, the consumer answers with ev_ready.
interface button_press_arbiter_if #(
  parameter int IDW = 2
);
  logic           ev_valid;
  logic           ev_ready;
  logic [IDW-1:0] ev_id;

  modport master (output ev_valid, output ev_id, input ev_ready);
  modport slave  (input ev_valid, input ev_id, output ev_ready);
endinterface

// File: rtl/button_press_arbiter_debounce.sv
// One button: 2-FF synchroniser followed by a tick-sampled debounce counter.
module button_debounce
  import button_pkg::*;
#(
  parameter int STABLE = DEF_STABLE
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = clog2(STABLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          flip;

  // rise is combinational so the pending bit sets on the same edge the level flips
  assign flip = tick && (sync2 != level) && (cnt == CNT_LAST);
  assign rise = flip && !level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (tick) begin
        if (sync2 == level) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          level <= ~level;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/button_press_arbiter.sv
// Button front end: shared sample prescaler, per-button debounce, sticky pending
// events and a round-robin arbiter serving one press at a time.
//
// state | meaning
// IDLE  | no offer outstanding; picks the next pending button round-robin
// OFFER | ev_id offered with ev_valid; waits for ev_ready
module button_press_arbiter
  import button_pkg::*;
#(
  parameter int N_BTN  = 4,
  parameter int DIV    = DEF_DIV,
  parameter int STABLE = DEF_STABLE,
  parameter int IDW    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_BTN-1:0]        btn,
  input  logic                    ovf_clr,
  button_press_arbiter_if.master  ev,
  output logic [N_BTN-1:0]        pressed,
  output logic                    overflow
);
  localparam int PW = clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [IDW-1:0] ID_LAST = IDW'(N_BTN - 1);

  logic [PW-1:0]    presc;
  logic             tick;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] pending_n;
  logic [N_BTN-1:0] clr;
  logic             ovf_set;

  arb_state_t       state;
  arb_state_t       state_n;
  logic [IDW-1:0]   ev_id_q;
  logic [IDW-1:0]   ev_id_n;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   last_grant_n;
  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   pick;
  logic             found;
  logic             accept;

  assign tick = (presc == PRESC_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) presc <= '0;
    else if (tick) presc <= '0;
    else presc <= presc + 1'b1;
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    button_debounce #(.STABLE(STABLE)) u_debounce (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .raw   (btn[i]),
      .level (pressed[i]),
      .rise  (rise[i])
    );
  end

  // A rise on the button being accepted re-arms it as a fresh event
  assign pending_n = rise | (pending & ~clr);
  assign ovf_set   = |(rise & pending & ~clr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= pending_n;
      overflow <= ovf_set | (overflow & ~ovf_clr);
    end
  end

  always_comb begin
    state_n      = state;
    ev_id_n      = ev_id_q;
    last_grant_n = last_grant;
    accept       = 1'b0;
    clr          = '0;
    found        = 1'b0;
    pick         = '0;
    cand         = last_grant;

    for (int k = 0; k < N_BTN; k++) begin
      cand = (cand == ID_LAST) ? '0 : cand + 1'b1;
      if (!found && pending[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end

    case (state)
      IDLE: begin
        if (found) begin
          ev_id_n = pick;
          state_n = OFFER;
        end
      end
      OFFER: begin
        if (ev.ev_ready) begin
          accept       = 1'b1;
          clr[ev_id_q] = 1'b1;
          last_grant_n = ev_id_q;
          state_n      = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ev_id_q    <= '0;
      last_grant <= ID_LAST;
    end else begin
      state      <= state_n;
      ev_id_q    <= ev_id_n;
      last_grant <= last_grant_n;
    end
  end

  assign ev.ev_valid = (state == OFFER);
  assign ev.ev_id    = ev_id_q;

endmodule

// File: tb/tb_button_press_arbiter.sv
// Bench for button_press_arbiter: press-pattern table plus hand sequences for offer hold,
// overflow and reset, with an expected-event queue checked at each accepted offer.
module tb_button_press_arbiter;

  typedef struct packed {
    logic [3:0] mask;
    logic [2:0] n_ev;
    logic [7:0] ids;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn = 4'b0000;
  logic       ovf_clr = 1'b0;
  logic [3:0] pressed;
  logic       overflow;

  button_press_arbiter_if #(.IDW(2)) evif ();

  button_press_arbiter #(
    .N_BTN  (4),
    .DIV    (16),
    .STABLE (4),
    .IDW    (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn      (btn),
    .ovf_clr  (ovf_clr),
    .ev       (evif.master),
    .pressed  (pressed),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   exp_q[$];
  int   acc_t[$];
  vec_t vecs[6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pressed(input logic [3:0] want, input int limit, input string name);
    for (int i = 0; i < limit && pressed !== want; i++) step(1);
    chk(name, int'(pressed), int'(want));
  endtask

  function automatic vec_t mkv(input logic [3:0] m, input int n,
                               input int a, input int b, input int c, input int d);
    vec_t v;
    v.mask = m;
    v.n_ev = 3'(n);
    v.ids  = {2'(d), 2'(c), 2'(b), 2'(a)};
    return v;
  endfunction

  // Scoreboard: every accepted offer must match the oldest expected id
  always @(negedge clk) begin
    if (!reset && evif.ev_valid && evif.ev_ready) begin
      acc_t.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got id %0d expected none", evif.ev_id);
      end else begin
        chk("event_id", int'(evif.ev_id), exp_q.pop_front());
      end
    end
  end

  initial begin
    int c;

    // last_grant history: after test 1 it is 2
    vecs[0] = mkv(4'b0011, 2, 0, 1, 0, 0);
    vecs[1] = mkv(4'b0001, 1, 0, 0, 0, 0);
    vecs[2] = mkv(4'b1001, 2, 3, 0, 0, 0);
    vecs[3] = mkv(4'b1111, 4, 1, 2, 3, 0);
    vecs[4] = mkv(4'b0110, 2, 1, 2, 0, 0);
    vecs[5] = mkv(4'b1010, 2, 3, 1, 0, 0);

    evif.ev_ready = 1'b1;
    step(3);
    chk("reset_ev_valid", int'(evif.ev_valid), 0);
    chk("reset_ev_id", int'(evif.ev_id), 0);
    chk("reset_pressed", int'(pressed), 0);
    chk("reset_overflow", int'(overflow), 0);
    reset = 1'b0;
    step(2);

    // Test 1: steady press of button 2
    acc_t.delete();
    btn[2] = 1'b1;
    exp_q.push_back(2);
    c = 0;
    while (c < 100 && !pressed[2]) begin
      step(1);
      c++;
    end
    chk("t1_latency_in_51_66", int'(c >= 51 && c <= 66), 1);
    step(1);
    chk("t1_valid", int'(evif.ev_valid), 1);
    chk("t1_id", int'(evif.ev_id), 2);
    step(1);
    chk("t1_valid_one_cycle", int'(evif.ev_valid), 0);
    step(100);
    chk("t1_single_event", acc_t.size(), 1);
    btn = 4'b0000;
    wait_pressed(4'b0000, 100, "t1_release");

    // Test 2: short bounce never debounces
    acc_t.delete();
    btn[1] = 1'b1;
    step(40);
    btn[1] = 1'b0;
    step(100);
    chk("t2_pressed", int'(pressed), 0);
    chk("t2_overflow", int'(overflow), 0);
    chk("t2_no_event", acc_t.size(), 0);

    // Table: simultaneous presses, round-robin order, two cycles per event
    for (int i = 0; i < 6; i++) begin
      acc_t.delete();
      btn = vecs[i].mask;
      for (int j = 0; j < int'(vecs[i].n_ev); j++)
        exp_q.push_back(int'(vecs[i].ids[2*j +: 2]));
      for (int k = 0; k < 200 && !(exp_q.size() == 0 && pressed == vecs[i].mask); k++)
        step(1);
      chk("vec_pressed", int'(pressed), int'(vecs[i].mask));
      chk("vec_all_served", exp_q.size(), 0);
      chk("vec_event_count", acc_t.size(), int'(vecs[i].n_ev));
      for (int j = 1; j < acc_t.size(); j++)
        chk("vec_event_gap", acc_t[j] - acc_t[j-1], 2);
      step(10);
      chk("vec_no_extra", acc_t.size(), int'(vecs[i].n_ev));
      btn = 4'b0000;
      wait_pressed(4'b0000, 100, "vec_release");
    end

    // Test 4: offer held while ev_ready is low
    acc_t.delete();
    evif.ev_ready = 1'b0;
    btn[3] = 1'b1;
    exp_q.push_back(3);
    for (int k = 0; k < 120 && !evif.ev_valid; k++) step(1);
    chk("t4_valid", int'(evif.ev_valid), 1);
    chk("t4_id", int'(evif.ev_id), 3);
    for (int k = 0; k < 20; k++) begin
      step(1);
      chk("t4_hold", int'({evif.ev_valid, evif.ev_id}), 7);
    end
    evif.ev_ready = 1'b1;
    step(1);
    chk("t4_accept_first_ready", int'(evif.ev_valid), 0);
    chk("t4_event_count", acc_t.size(), 1);
    btn = 4'b0000;
    wait_pressed(4'b0000, 100, "t4_release");

    // Test 5: second press while still pending sets overflow
    acc_t.delete();
    evif.ev_ready = 1'b0;
    btn[3] = 1'b1;
    exp_q.push_back(3);
    wait_pressed(4'b1000, 100, "t5_press1");
    chk("t5_no_ovf_yet", int'(overflow), 0);
    btn[3] = 1'b0;
    wait_pressed(4'b0000, 100, "t5_release1");
    btn[3] = 1'b1;
    wait_pressed(4'b1000, 100, "t5_press2");
    chk("t5_overflow_set", int'(overflow), 1);
    chk("t5_offer", int'({evif.ev_valid, evif.ev_id}), 7);
    evif.ev_ready = 1'b1;
    step(1);
    chk("t5_accepted", int'(evif.ev_valid), 0);
    step(5);
    chk("t5_no_second_offer", int'(evif.ev_valid), 0);
    chk("t5_single_event", acc_t.size(), 1);
    chk("t5_overflow_sticky", int'(overflow), 1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("t5_overflow_cleared", int'(overflow), 0);
    btn = 4'b0000;
    wait_pressed(4'b0000, 100, "t5_release2");

    // Test 6: reset mid-offer, then button 0 regains first priority
    acc_t.delete();
    btn[0] = 1'b1;
    exp_q.push_back(0);
    wait_pressed(4'b0001, 100, "t6_press0");
    step(3);
    chk("t6_grant0", acc_t.size(), 1);
    btn = 4'b0000;
    wait_pressed(4'b0000, 100, "t6_release0");
    evif.ev_ready = 1'b0;
    btn[1] = 1'b1;
    for (int k = 0; k < 120 && !evif.ev_valid; k++) step(1);
    chk("t6_offer_before_reset", int'(evif.ev_valid), 1);
    reset = 1'b1;
    #1;
    chk("t6_async_valid", int'(evif.ev_valid), 0);
    chk("t6_async_pressed", int'(pressed), 0);
    chk("t6_async_overflow", int'(overflow), 0);
    btn = 4'b0000;
    step(2);
    reset = 1'b0;
    step(2);
    acc_t.delete();
    evif.ev_ready = 1'b1;
    btn = 4'b1001;
    exp_q.push_back(0);
    exp_q.push_back(3);
    for (int k = 0; k < 200 && !(exp_q.size() == 0 && pressed == 4'b1001); k++) step(1);
    chk("t6_all_served", exp_q.size(), 0);
    chk("t6_event_count", acc_t.size(), 2);
    btn = 4'b0000;
    wait_pressed(4'b0000, 100, "t6_release");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
